// File: rtl/pio_tx_fifo.sv
// Transmit FIFO from the host bus into one PIO state machine's PULL path.
// Show-ahead head word, explicit occupancy count, blocking-pull stall and sticky debug flags.
module pio_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       pull_req,
    input  logic                       pull_block,
    output logic [WIDTH-1:0]           pull_data,
    output logic                       pull_ack,
    output logic                       stall,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       flush,
    input  logic                       clr_over,
    input  logic                       clr_stall,
    output logic                       tx_over,
    output logic                       tx_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             pop;
    logic             push;
    logic             over_set;
    logic             stall_set;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;

    // A flush cycle swallows both ports so a restarting state machine sees a clean FIFO.
    assign pop       = pull_req & ~empty & ~flush;
    assign push      = wr_en & ~flush & (~full | pop);
    assign over_set  = wr_en & ~flush & full & ~pop;
    assign stall     = pull_req & pull_block & empty;
    assign stall_set = stall & ~flush;
    assign pull_ack  = pull_req & ~flush & (~empty | ~pull_block);

    // Gated to zero while empty so the port never exposes stale storage.
    assign pull_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_over  <= 1'b0;
            tx_stall <= 1'b0;
        end else begin
            if (over_set)
                tx_over <= 1'b1;
            else if (clr_over)
                tx_over <= 1'b0;
            if (stall_set)
                tx_stall <= 1'b1;
            else if (clr_stall)
                tx_stall <= 1'b0;
        end
    end
endmodule
